// File: rtl/wb_commit_tlb.sv
// wb_commit_tlb: writeback/commit stage with TLB maintenance.
// Commits GPR/CSR writes, exception/ERTN flushes and TLB ops; TLBRD takes
// two cycles (IDLE then RD_WAIT) so the registered TLB array can be read.
// Optional feature macro: WB_TLBFILL_LFSR_EN selects a 16-bit Galois LFSR
// for the TLBFILL index instead of the default round-robin counter.
module wb_commit_tlb #(
  parameter  int TLBNUM = 16,
  parameter  int CNT_W  = 32,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ms_to_ws_valid,
  output logic             ws_allow_in,
  input  logic [31:0]      ms_pc,
  input  logic [31:0]      ms_result,
  input  logic [31:0]      ms_vaddr,
  input  logic             ms_gr_we,
  input  logic [4:0]       ms_dest,
  input  logic             ms_csr_re,
  input  logic             ms_csr_we,
  input  logic [13:0]      ms_csr_num,
  input  logic [31:0]      ms_csr_wmask,
  input  logic [31:0]      ms_csr_wvalue,
  input  logic             ms_ertn,
  input  logic             ms_ex,
  input  logic [5:0]       ms_ecode,
  input  logic [8:0]       ms_esubcode,
  input  logic [2:0]       ms_tlbop,
  input  logic [4:0]       ms_invtlb_op,
  input  logic             ms_srch_hit,
  input  logic [IDXW-1:0]  ms_srch_index,
  output logic [13:0]      csr_num,
  output logic             csr_re,
  input  logic [31:0]      csr_rvalue,
  output logic             csr_we,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             ertn_flush,
  output logic             wb_ex,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_vaddr,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  input  logic [IDXW-1:0]  tlbidx_index,
  output logic             tlb_we,
  output logic [IDXW-1:0]  tlb_w_index,
  output logic [IDXW-1:0]  tlb_r_index,
  output logic             tlbrd_we,
  output logic             tlbsrch_we,
  output logic             tlbsrch_hit,
  output logic [IDXW-1:0]  tlbsrch_index,
  output logic             invtlb_valid,
  output logic [4:0]       invtlb_op,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam logic [2:0] OP_SRCH = 3'd1, OP_RD = 3'd2, OP_WR = 3'd3,
                         OP_FILL = 3'd4, OP_INV = 3'd5;

  typedef enum logic {S_IDLE, S_RD_WAIT} state_e;

  state_e            state_q, state_d;
  logic              ws_valid_q, ws_valid_d;
  logic              ws_ready_go, commit, ok, flush;
  logic [CNT_W-1:0]  retire_q;
  logic [IDXW-1:0]   rd_idx_q, fill_idx;

  logic [31:0] pc_q, result_q, vaddr_q, wmask_q, wvalue_q;
  logic        gr_we_q, csr_re_q, csr_we_q, ertn_q, ex_q, hit_q;
  logic [4:0]  dest_q, invop_q;
  logic [13:0] csr_num_q;
  logic [5:0]  ecode_q;
  logic [8:0]  esub_q;
  logic [2:0]  tlbop_q;
  logic [IDXW-1:0] sidx_q;

  // Stage register: captures the MEM payload on every accepted handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q <= '0; result_q <= '0; vaddr_q <= '0; wmask_q <= '0; wvalue_q <= '0;
      gr_we_q <= 1'b0; csr_re_q <= 1'b0; csr_we_q <= 1'b0; ertn_q <= 1'b0;
      ex_q <= 1'b0; hit_q <= 1'b0; dest_q <= '0; invop_q <= '0;
      csr_num_q <= '0; ecode_q <= '0; esub_q <= '0; tlbop_q <= '0; sidx_q <= '0;
    end else if (ms_to_ws_valid && ws_allow_in) begin
      pc_q <= ms_pc; result_q <= ms_result; vaddr_q <= ms_vaddr;
      wmask_q <= ms_csr_wmask; wvalue_q <= ms_csr_wvalue;
      gr_we_q <= ms_gr_we; csr_re_q <= ms_csr_re; csr_we_q <= ms_csr_we;
      ertn_q <= ms_ertn; ex_q <= ms_ex; hit_q <= ms_srch_hit;
      dest_q <= ms_dest; invop_q <= ms_invtlb_op; csr_num_q <= ms_csr_num;
      ecode_q <= ms_ecode; esub_q <= ms_esubcode; tlbop_q <= ms_tlbop;
      sidx_q <= ms_srch_index;
    end
  end

  // Valid, FSM state, latched read index and retire counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      state_q    <= S_IDLE;
      rd_idx_q   <= '0;
      retire_q   <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      state_q    <= state_d;
      if (state_q == S_IDLE) rd_idx_q <= tlbidx_index;
      if (ok) retire_q <= retire_q + CNT_W'(1);
    end
  end

  // TLBRD next state: a non-excepting rd spends one extra cycle in RD_WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ws_valid_q && tlbop_q == OP_RD && !ex_q) state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // TLBRD outputs: hold the stage in IDLE, read from the latched index in RD_WAIT
  always_comb begin
    ws_ready_go = 1'b1;
    tlb_r_index = tlbidx_index;
    if (state_q == S_IDLE) begin
      if (ws_valid_q && tlbop_q == OP_RD && !ex_q) ws_ready_go = 1'b0;
    end else begin
      tlb_r_index = rd_idx_q;
    end
  end

  // Handshake, flush and next valid
  always_comb begin
    commit      = ws_valid_q && ws_ready_go;
    ok          = commit && !ex_q;
    flush       = commit && (ex_q || ertn_q);
    ws_allow_in = !ws_valid_q || ws_ready_go;
    ws_valid_d  = ws_valid_q;
    if (flush)            ws_valid_d = 1'b0;
    else if (ws_allow_in) ws_valid_d = ms_to_ws_valid;
  end

`ifdef WB_TLBFILL_LFSR_EN
  logic [15:0] lfsr_q;
  // Free-running Galois LFSR; low bits pick the fill victim
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
  assign fill_idx = lfsr_q[IDXW-1:0];
`else
  logic [IDXW-1:0] fill_q;
  // Round-robin fill victim; power-of-two depth wraps naturally
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     fill_q <= '0;
    else if (ok && tlbop_q == OP_FILL) fill_q <= fill_q + IDXW'(1);
  end
  assign fill_idx = fill_q;
`endif

  // Commit-side outputs; every enable is gated by a non-excepting commit
  always_comb begin
    wb_ex         = commit && ex_q;
    ertn_flush    = commit && ertn_q && !ex_q;
    rf_we         = ok && gr_we_q;
    rf_waddr      = dest_q;
    rf_wdata      = csr_re_q ? csr_rvalue : result_q;
    csr_re        = 1'b1;
    csr_num       = csr_num_q;
    csr_we        = ok && csr_we_q;
    csr_wmask     = wmask_q;
    csr_wvalue    = wvalue_q;
    tlb_we        = ok && (tlbop_q == OP_WR || tlbop_q == OP_FILL);
    tlb_w_index   = (tlbop_q == OP_FILL) ? fill_idx : tlbidx_index;
    tlbrd_we      = ok && tlbop_q == OP_RD;
    tlbsrch_we    = ok && tlbop_q == OP_SRCH;
    tlbsrch_hit   = hit_q;
    tlbsrch_index = sidx_q;
    invtlb_valid  = ok && tlbop_q == OP_INV;
    invtlb_op     = invtlb_valid ? invop_q : 5'd0;
    wb_pc         = pc_q;
    wb_vaddr      = vaddr_q;
    wb_ecode      = ecode_q;
    wb_esubcode   = esub_q;
    debug_wb_pc       = pc_q;
    debug_wb_rf_we    = {4{rf_we}};
    debug_wb_rf_wnum  = dest_q;
    debug_wb_rf_wdata = rf_wdata;
    retire_cnt        = retire_q;
  end
endmodule

// File: tb/tb_wb_commit_tlb.sv
// Bench for wb_commit_tlb: transaction-level model (pending instruction plus
// remaining wait cycles) compared every cycle, plus directed literal checks.
module tb_wb_commit_tlb;
  localparam int TLBNUM = 8, CNT_W = 32, IDXW = 3;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  logic ms_to_ws_valid, ws_allow_in;
  logic [31:0] ms_pc, ms_result, ms_vaddr, ms_csr_wmask, ms_csr_wvalue;
  logic ms_gr_we, ms_csr_re, ms_csr_we, ms_ertn, ms_ex, ms_srch_hit;
  logic [4:0] ms_dest, ms_invtlb_op;
  logic [13:0] ms_csr_num;
  logic [5:0] ms_ecode;
  logic [8:0] ms_esubcode;
  logic [2:0] ms_tlbop;
  logic [IDXW-1:0] ms_srch_index, tlbidx_index;
  logic [31:0] csr_rvalue;
  logic [13:0] csr_num;
  logic csr_re, csr_we, ertn_flush, wb_ex, tlb_we, tlbrd_we, tlbsrch_we, tlbsrch_hit;
  logic invtlb_valid, rf_we;
  logic [31:0] csr_wmask, csr_wvalue, wb_pc, wb_vaddr, rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic [IDXW-1:0] tlb_w_index, tlb_r_index, tlbsrch_index;
  logic [4:0] invtlb_op, rf_waddr, debug_wb_rf_wnum;
  logic [3:0] debug_wb_rf_we;
  logic [CNT_W-1:0] retire_cnt;

  wb_commit_tlb #(.TLBNUM(TLBNUM), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .ms_to_ws_valid(ms_to_ws_valid), .ws_allow_in(ws_allow_in),
    .ms_pc(ms_pc), .ms_result(ms_result), .ms_vaddr(ms_vaddr), .ms_gr_we(ms_gr_we),
    .ms_dest(ms_dest), .ms_csr_re(ms_csr_re), .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
    .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue), .ms_ertn(ms_ertn), .ms_ex(ms_ex),
    .ms_ecode(ms_ecode), .ms_esubcode(ms_esubcode), .ms_tlbop(ms_tlbop),
    .ms_invtlb_op(ms_invtlb_op), .ms_srch_hit(ms_srch_hit), .ms_srch_index(ms_srch_index),
    .csr_num(csr_num), .csr_re(csr_re), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .ertn_flush(ertn_flush), .wb_ex(wb_ex),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .tlbidx_index(tlbidx_index), .tlb_we(tlb_we), .tlb_w_index(tlb_w_index),
    .tlb_r_index(tlb_r_index), .tlbrd_we(tlbrd_we), .tlbsrch_we(tlbsrch_we),
    .tlbsrch_hit(tlbsrch_hit), .tlbsrch_index(tlbsrch_index), .invtlb_valid(invtlb_valid),
    .invtlb_op(invtlb_op), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt(retire_cnt)
  );

  typedef struct packed {
    bit v; bit [31:0] pc, result, vaddr, wmask, wvalue;
    bit gr_we, csr_re, csr_we, ertn, ex, hit;
    bit [4:0] dest, invop; bit [13:0] csr_num; bit [5:0] ecode; bit [8:0] esub;
    bit [2:0] op; bit [IDXW-1:0] sidx;
  } ins_t;

  int nvec = 0, nerr = 0;

  // model state: instruction waiting in the stage and cycles left before it commits
  bit pend; ins_t p, last; int cd; int unsigned retire; int fillc;
  bit [15:0] lfsr; bit [IDXW-1:0] rdidx;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic void model_reset();
    pend = 0; p = '0; last = '0; cd = 0; retire = 0; fillc = 0; lfsr = 16'hACE1; rdidx = '0;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t r; int o;
    r = '0;
    r.v = ($urandom_range(0, 3) != 0);
    r.pc = $urandom; r.result = $urandom; r.vaddr = $urandom;
    r.wmask = $urandom; r.wvalue = $urandom;
    r.gr_we = 1'($urandom); r.csr_re = 1'($urandom); r.csr_we = 1'($urandom);
    r.ertn = ($urandom_range(0, 9) == 0); r.ex = ($urandom_range(0, 5) == 0);
    r.hit = 1'($urandom); r.dest = 5'($urandom); r.invop = 5'($urandom);
    r.csr_num = 14'($urandom); r.ecode = 6'($urandom); r.esub = 9'($urandom);
    o = $urandom_range(0, 8);
    r.op = (o > 5) ? 3'd0 : 3'(o);
    r.sidx = IDXW'($urandom);
    return r;
  endfunction

  // one cycle: drive at negedge, compare against model, advance model to the posedge
  task automatic step(input ins_t i, input logic [31:0] rval, input logic [IDXW-1:0] tidx);
    bit commit, ok, flush, allow;
    logic [IDXW-1:0] fexp;
    @(negedge clk);
    ms_to_ws_valid = i.v; ms_pc = i.pc; ms_result = i.result; ms_vaddr = i.vaddr;
    ms_gr_we = i.gr_we; ms_dest = i.dest; ms_csr_re = i.csr_re; ms_csr_we = i.csr_we;
    ms_csr_num = i.csr_num; ms_csr_wmask = i.wmask; ms_csr_wvalue = i.wvalue;
    ms_ertn = i.ertn; ms_ex = i.ex; ms_ecode = i.ecode; ms_esubcode = i.esub;
    ms_tlbop = i.op; ms_invtlb_op = i.invop; ms_srch_hit = i.hit; ms_srch_index = i.sidx;
    csr_rvalue = rval; tlbidx_index = tidx;
    #1;
    commit = pend && cd == 0;
    ok     = commit && !p.ex;
    flush  = commit && (p.ex || p.ertn);
    allow  = !pend || cd == 0;
`ifdef WB_TLBFILL_LFSR_EN
    fexp = lfsr[IDXW-1:0];
`else
    fexp = IDXW'(fillc);
`endif
    chk("allow_in", 32'(ws_allow_in), 32'(allow));
    chk("wb_ex", 32'(wb_ex), 32'(commit && p.ex));
    chk("ertn_flush", 32'(ertn_flush), 32'(commit && p.ertn && !p.ex));
    chk("rf_we", 32'(rf_we), 32'(ok && p.gr_we));
    chk("dbg_rf_we", 32'(debug_wb_rf_we), 32'({4{ok && p.gr_we}}));
    if (ok && p.gr_we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(p.dest));
      chk("rf_wdata", rf_wdata, p.csr_re ? rval : p.result);
      chk("dbg_wdata", debug_wb_rf_wdata, p.csr_re ? rval : p.result);
    end
    chk("csr_re", 32'(csr_re), 32'(1));
    chk("csr_we", 32'(csr_we), 32'(ok && p.csr_we));
    if (ok && p.csr_we) begin
      chk("csr_num", 32'(csr_num), 32'(p.csr_num));
      chk("csr_wmask", csr_wmask, p.wmask);
      chk("csr_wvalue", csr_wvalue, p.wvalue);
    end
    chk("tlb_we", 32'(tlb_we), 32'(ok && (p.op == 3 || p.op == 4)));
    if (ok && p.op == 3) chk("tlbwr_idx", 32'(tlb_w_index), 32'(tidx));
    if (ok && p.op == 4) chk("tlbfill_idx", 32'(tlb_w_index), 32'(fexp));
    chk("tlbrd_we", 32'(tlbrd_we), 32'(ok && p.op == 2));
    chk("tlbsrch_we", 32'(tlbsrch_we), 32'(ok && p.op == 1));
    if (ok && p.op == 1) begin
      chk("srch_hit", 32'(tlbsrch_hit), 32'(p.hit));
      chk("srch_idx", 32'(tlbsrch_index), 32'(p.sidx));
    end
    chk("invtlb_valid", 32'(invtlb_valid), 32'(ok && p.op == 5));
    chk("invtlb_op", 32'(invtlb_op), (ok && p.op == 5) ? 32'(p.invop) : 32'(0));
    if (commit && p.ex) begin
      chk("wb_pc", wb_pc, p.pc);
      chk("wb_vaddr", wb_vaddr, p.vaddr);
      chk("wb_ecode", 32'(wb_ecode), 32'(p.ecode));
      chk("wb_esub", 32'(wb_esubcode), 32'(p.esub));
    end
    chk("debug_pc", debug_wb_pc, last.pc);
    chk("retire", retire_cnt, retire);
    chk("tlb_r_index", 32'(tlb_r_index),
        (commit && p.op == 2 && !p.ex) ? 32'(rdidx) : 32'(tidx));
    // advance model
    if (commit) begin
      if (!p.ex) begin
        retire++;
        if (p.op == 4) fillc = (fillc + 1) % TLBNUM;
      end
      pend = 0;
    end else if (pend) begin
      cd = 0; rdidx = tidx;
    end
    if (allow && i.v) begin
      last = i;
      if (!flush) begin
        pend = 1; p = i; cd = (i.op == 2 && !i.ex) ? 1 : 0;
      end
    end
    lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    @(posedge clk);
  endtask

  ins_t b, x;

  initial begin
    ms_to_ws_valid = 0; ms_pc = 0; ms_result = 0; ms_vaddr = 0; ms_gr_we = 0; ms_dest = 0;
    ms_csr_re = 0; ms_csr_we = 0; ms_csr_num = 0; ms_csr_wmask = 0; ms_csr_wvalue = 0;
    ms_ertn = 0; ms_ex = 0; ms_ecode = 0; ms_esubcode = 0; ms_tlbop = 0; ms_invtlb_op = 0;
    ms_srch_hit = 0; ms_srch_index = 0; csr_rvalue = 0; tlbidx_index = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 resetn = 1;
    // reset state
    chk("rst_allow", 32'(ws_allow_in), 32'(1));
    chk("rst_pc", debug_wb_pc, 32'h0);
    chk("rst_rf_we", 32'(rf_we), 32'(0));
    chk("rst_tlb_we", 32'(tlb_we), 32'(0));
    chk("rst_wb_ex", 32'(wb_ex), 32'(0));
    chk("rst_retire", retire_cnt, 32'h0);

    b = '0;
    // ADD r5 = 0x1234
    x = '0; x.v = 1; x.pc = 32'h1c00_0000; x.gr_we = 1; x.dest = 5; x.result = 32'h1234;
    step(x, 32'h0, '0); #1;
    chk("add_rf_we", 32'(rf_we), 32'(1));
    chk("add_waddr", 32'(rf_waddr), 32'(5));
    chk("add_wdata", rf_wdata, 32'h1234);
    // CSRRD with exception
    x = '0; x.v = 1; x.pc = 32'h1c00_0004; x.gr_we = 1; x.dest = 6; x.csr_re = 1;
    x.csr_we = 1; x.csr_num = 14'h5; x.ex = 1; x.ecode = 6'hB;
    step(x, 32'hABCD, '0); #1;
    chk("ex_retire", retire_cnt, 32'd1);
    chk("ex_wb_ex", 32'(wb_ex), 32'(1));
    chk("ex_ecode", 32'(wb_ecode), 32'hB);
    chk("ex_rf_we", 32'(rf_we), 32'(0));
    chk("ex_csr_we", 32'(csr_we), 32'(0));
    x.pc = 32'h1c00_0008; x.ex = 0; x.csr_we = 0;  // offered while flush is active
    step(x, 32'hABCD, '0); #1;
    chk("flush_wb_ex", 32'(wb_ex), 32'(0));
    chk("flush_rf_we", 32'(rf_we), 32'(0));
    chk("flush_retire", retire_cnt, 32'd1);
    // TLBRD then ADD
    x = '0; x.v = 1; x.pc = 32'h1c00_0010; x.op = 3'd2;
    step(x, 32'h0, 3'd7); #1;
    chk("rd_allow0", 32'(ws_allow_in), 32'(0));
    chk("rd_ridx", 32'(tlb_r_index), 32'(7));
    chk("rd_we0", 32'(tlbrd_we), 32'(0));
    x = '0; x.v = 1; x.pc = 32'h1c00_0014; x.gr_we = 1; x.dest = 9; x.result = 32'h55;
    step(x, 32'h0, 3'd7); #1;
    chk("rd_we1", 32'(tlbrd_we), 32'(1));
    chk("rd_allow1", 32'(ws_allow_in), 32'(1));
    chk("rd_ridx1", 32'(tlb_r_index), 32'(7));
    step(x, 32'h0, 3'd7); #1;
    chk("rd_add_we", 32'(rf_we), 32'(1));
    chk("rd_add_data", rf_wdata, 32'h55);
    // nine fills: round-robin wraps after TLBNUM-1
    for (int k = 1; k <= 9; k++) begin
      x = '0; x.v = 1; x.pc = 32'h1c00_0100 + 32'(k); x.op = 3'd4;
      step(x, 32'h0, '0); #1;
      chk("fill_we", 32'(tlb_we), 32'(1));
`ifndef WB_TLBFILL_LFSR_EN
      chk("fill_idx", 32'(tlb_w_index), 32'((k - 1) % TLBNUM));
`endif
    end
    x = '0; x.v = 1; x.op = 3'd3;
    step(x, 32'h0, 3'd3); #1;
    chk("wr_we", 32'(tlb_we), 32'(1));
    chk("wr_idx", 32'(tlb_w_index), 32'(3));
    x = '0; x.v = 1; x.op = 3'd5; x.invop = 5'd5;
    step(x, 32'h0, '0); #1;
    chk("inv_valid", 32'(invtlb_valid), 32'(1));
    chk("inv_op", 32'(invtlb_op), 32'(5));
    x = '0; x.v = 1; x.ertn = 1;
    step(x, 32'h0, '0); #1;
    chk("ertn_flush", 32'(ertn_flush), 32'(1));
    chk("ertn_no_ex", 32'(wb_ex), 32'(0));
    // random traffic
    for (int n = 0; n < 3000; n++) step(rnd_ins(), $urandom, IDXW'($urandom));
    // reset during RD_WAIT
    x = '0; x.v = 1; x.op = 3'd2;
    step(x, 32'h0, 3'd2);
    step(b, 32'h0, 3'd2);
    #1 chk("pre_rst_rdwe", 32'(tlbrd_we), 32'(1));
    resetn = 0; #1;
    chk("mid_rst_rdwe", 32'(tlbrd_we), 32'(0));
    chk("mid_rst_allow", 32'(ws_allow_in), 32'(1));
    chk("mid_rst_retire", retire_cnt, 32'h0);
    chk("mid_rst_pc", debug_wb_pc, 32'h0);
    model_reset();
    resetn = 1;
    for (int n = 0; n < 200; n++) step(rnd_ins(), $urandom, IDXW'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_commit_tlb.md
# wb_commit_tlb

Parametrised writeback/commit stage, stage 5 of the five-stage LoongArch pipeline. It takes one instruction per cycle from the MEM stage and commits its side effects: GPR write, CSR write, exception/ERTN flush, and TLB maintenance (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) to a TLB of configurable depth. Over the previous writeback stage it adds a two-cycle TLBRD with stall, a deterministic TLBFILL replacement index, side-effect suppression on exceptions, and a retired-instruction counter.

## Interface
- TLBNUM, 16, TLB entries; power of two, 4..64; IDXW = $clog2(TLBNUM)
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- ms_to_ws_valid  in  1  MEM presents an instruction
- ws_allow_in  out  1  stage accepts this cycle
- ms_pc / ms_result / ms_vaddr  in  32 each  PC, ALU/load result, bad vaddr
- ms_gr_we / ms_dest  in  1 / 5  GPR write enable / address
- ms_csr_re / ms_csr_we / ms_csr_num  in  1 / 1 / 14  CSR read, write, number
- ms_csr_wmask / ms_csr_wvalue  in  32 / 32  CSR write mask, value
- ms_ertn / ms_ex  in  1 / 1  ERTN; exception pending
- ms_ecode / ms_esubcode  in  6 / 9  exception codes
- ms_tlbop  in  3  0 none, 1 srch, 2 rd, 3 wr, 4 fill, 5 inv
- ms_invtlb_op  in  5  INVTLB op
- ms_srch_hit / ms_srch_index  in  1 / IDXW  TLBSRCH result
- csr_num / csr_re / csr_rvalue  out / out / in  14 / 1 / 32  CSR read port
- csr_we / csr_wmask / csr_wvalue  out  1 / 32 / 32  CSR write port
- ertn_flush / wb_ex  out  1 / 1  flush requests
- wb_pc / wb_vaddr / wb_ecode / wb_esubcode  out  32 / 32 / 6 / 9  exception info
- tlbidx_index  in  IDXW  CSR.TLBIDX.index
- tlb_we / tlb_w_index  out  1 / IDXW  TLB entry write
- tlb_r_index  out  IDXW  TLB read address, registered array
- tlbrd_we  out  1  load TLBRD result into CSRs
- tlbsrch_we / tlbsrch_hit / tlbsrch_index  out  1 / 1 / IDXW  TLBSRCH update to CSR
- invtlb_valid / invtlb_op  out  1 / 5
- rf_we / rf_waddr / rf_wdata  out  1 / 5 / 32  GPR write and forward to ID
- debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32 / 4 / 5 / 32
- retire_cnt  out  CNT_W  committed-instruction count

## Operation
- Stage register loads all ms_* fields when ms_to_ws_valid && ws_allow_in. ws_valid <= ms_to_ws_valid whenever ws_allow_in.
- commit = ws_valid && ws_ready_go. Every side-effect enable is qualified by commit.
- wb_ex = commit && ex. ertn_flush = commit && ertn && !ex. Exception takes priority.
- When ex is set: rf_we, csr_we, tlb_we, tlbrd_we, tlbsrch_we and invtlb_valid are 0.
- rf_wdata = csr_re ? csr_rvalue : result. rf_we = commit && gr_we && !ex.
- csr_re = 1 constantly; csr_num comes from the stage register.
- TLB ops on commit, no exception:
  - srch: tlbsrch_we = 1, with hit and index forwarded.
  - wr: tlb_we = 1, tlb_w_index = tlbidx_index.
  - fill: tlb_we = 1, tlb_w_index = fill index.
  - inv: invtlb_valid = 1, invtlb_op = stored op; otherwise invtlb_op = 0.
- TLBRD FSM:
  - IDLE: tlb_r_index = tlbidx_index. A valid rd instruction makes ws_ready_go = 0 and moves the FSM to RD_WAIT.
  - RD_WAIT: ws_ready_go = 1, tlbrd_we = 1 (commit cycle), then back to IDLE.
  - A rd with ex set commits in one cycle and does not enter RD_WAIT.
- ws_allow_in = !ws_valid || ws_ready_go.
- Flush: on the cycle wb_ex or ertn_flush is asserted, ws_valid is forced to 0 the next cycle, whatever ms_to_ws_valid is.
- retire_cnt increments by 1 on each commit with !ex. It wraps modulo 2^CNT_W. ERTN counts; excepting instructions do not.

## Timing
- Reset values:
  - ws_valid = 0, FSM = IDLE, retire_cnt = 0.
  - Stage register = 0, so debug_wb_pc = 0 and all enables are 0.
  - Fill state as in Configuration.
- Latency: one cycle from accept to commit; two cycles for a non-excepting TLBRD.
- All outputs are combinational from registered state plus csr_rvalue and tlbidx_index. No output depends combinationally on ms_* inputs.
- Asserting resetn low mid-RD_WAIT returns to IDLE asynchronously and drops all enables immediately.

## Configuration
- WB_TLBFILL_LFSR_EN defined:
  - Fill index = lfsr[IDXW-1:0], from a 16-bit Galois LFSR with taps 0xB400 and seed 16'hACE1.
  - The LFSR advances every clock.
- WB_TLBFILL_LFSR_EN undefined:
  - Fill index comes from an IDXW-bit round-robin counter, reset value 0.
  - The counter increments after each committed fill and wraps from TLBNUM-1 to 0.

## Test plan
- ADD, dest r5, result 0x1234 → next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234, retire_cnt 0→1.
- CSRRD num 0x5, csr_rvalue = 0xABCD, ms_csr_we = 1, ms_ex = 1, ecode 0xB → wb_ex = 1, wb_ecode = 0xB, rf_we = csr_we = 0, ws_valid = 0 next cycle, retire_cnt unchanged.
- TLBRD with tlbidx_index = 7 followed by an ADD → tlb_r_index = 7, ws_allow_in = 0 for one cycle, tlbrd_we pulses in cycle 2, ADD commits in cycle 3.
- Macro undefined, TLBNUM = 4, five TLBFILLs → tlb_w_index = 0, 1, 2, 3, 0.
- Macro defined, reset then TLBFILL at cycle 0 → tlb_w_index = 16'hACE1[IDXW-1:0]; TLBWR with tlbidx_index = 3 → tlb_w_index = 3.
- INVTLB op 5 with ms_ex = 0 → invtlb_valid = 1, invtlb_op = 5; ERTN with ms_ex = 0 → ertn_flush = 1 and no wb_ex.
